// File: rtl/vga_pkg.sv
// Shared video timing constants and the VRAM arbiter state encoding.
package vga_pkg;

  localparam int HWIDTH  = 640;
  localparam int VWIDTH  = 480;
  localparam int FB_SIZE = HWIDTH * VWIDTH;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RD_PEND,
    ARB_RD_DATA
  } arb_state_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Posted-write FIFO for the VRAM arbiter: address+data entries, power-of-two depth.
module vram_wr_fifo #(
  parameter int AW    = 19,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // NOTE: entry storage is deliberately not reset; count and pointers alone decide validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: push_addr, data: push_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_addr = mem[rd_ptr].addr;
  assign head_data = mem[rd_ptr].data;
  assign empty     = (count == '0);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads own pixel slots, CPU writes are posted
// and drained in free slots, CPU reads block behind all posted writes.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              video_on,
  input  logic [9:0]        posx,
  input  logic [9:0]        posy,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pixel_data,
  output logic              pixel_valid
);

  localparam int                CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_SIZE);

  arb_state_t        state, state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_oob;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CW-1:0]     count;
  logic              fifo_empty;
  logic              disp_slot, rd_issue, push, pop, rd_accept;
  logic              disp_d, blank_d;
  logic [ADDR_W-1:0] pix_addr;

  assign disp_slot = pix_en && video_on;

  // Row pitch 640 = 512 + 128, so posy*640 is two shifts and an add.
  assign pix_addr = ADDR_W'({posy, 9'b0}) + ADDR_W'({posy, 7'b0}) + ADDR_W'(posx);

  assign cpu_ready = !rst && (state == ARB_IDLE) &&
                     (cpu_we ? (count < CW'(FIFO_DEPTH)) : 1'b1);
  assign push      = cpu_req && cpu_ready && cpu_we;
  assign rd_accept = cpu_req && cpu_ready && !cpu_we;

  // A pending read only goes out once every earlier posted write has drained.
  assign rd_issue = !rst && !disp_slot && (state == ARB_RD_PEND) && fifo_empty;
  assign pop      = !rst && !disp_slot && !rd_issue && !fifo_empty;

  vram_wr_fifo #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (cpu_addr),
    .push_data (cpu_wdata),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .empty     (fifo_empty)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (rst) begin
      ram_addr = '0;
    end else if (disp_slot) begin
      ram_addr = pix_addr;
    end else if (rd_issue) begin
      ram_addr = rd_oob ? '0 : rd_addr;
    end else if (pop) begin
      ram_addr  = head_addr;
      ram_wdata = head_data;
      ram_we    = (head_addr < FB_LIMIT);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:    if (rd_accept) state_nxt = ARB_RD_PEND;
      ARB_RD_PEND: if (rd_issue)  state_nxt = ARB_RD_DATA;
      ARB_RD_DATA: state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  // RAM data lands one cycle after the address, so slot type is delayed to match.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid  <= 1'b0;
      cpu_rdata   <= '0;
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      disp_d      <= 1'b0;
      blank_d     <= 1'b0;
      rd_addr     <= '0;
      rd_oob      <= 1'b0;
    end else begin
      cpu_rvalid <= (state == ARB_RD_DATA);
      if (state == ARB_RD_DATA) cpu_rdata <= rd_oob ? '0 : ram_rdata;
      disp_d      <= disp_slot;
      blank_d     <= pix_en && !video_on;
      pixel_valid <= disp_d;
      if (disp_d)       pixel_data <= ram_rdata;
      else if (blank_d) pixel_data <= '0;
      if (rd_accept) begin
        rd_addr <= cpu_addr;
        rd_oob  <= (cpu_addr >= FB_LIMIT);
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: inputs driven and outputs sampled on the falling edge,
// with a behavioural 1-cycle-latency RAM and a log of every RAM write.
module tb_vram_arbiter;
  import vga_pkg::*;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_en, video_on;
  logic [9:0]        posx, posy;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [DATA_W-1:0] pixel_data;
  logic              pixel_valid;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic [DATA_W-1:0] mem [0:FB_SIZE-1];
  wr_t               wlog[$];
  int                vectors = 0;
  int                miscompares = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .video_on    (video_on),
    .posx        (posx),
    .posy        (posy),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ready   (cpu_ready),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid)
  );

  always @(posedge clk) begin
    if (ram_we) begin
      if (ram_addr < ADDR_W'(FB_SIZE)) mem[ram_addr] <= ram_wdata;
      wlog.push_back(wr_t'{a: ram_addr, d: ram_wdata});
    end
    ram_rdata <= (ram_addr < ADDR_W'(FB_SIZE)) ? mem[ram_addr] : '0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends just after a falling edge; holds the request until it is accepted.
  task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic done = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    for (int i = 0; i < 64 && !done; i++) begin
      #1;
      done = cpu_ready;
      @(negedge clk);
    end
    cpu_req = 1'b0;
    check("cpu_accept", done, 1);
  endtask

  task automatic wait_rvalid(output logic got, output logic [DATA_W-1:0] data);
    got = 1'b0; data = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (cpu_rvalid) begin got = 1'b1; data = cpu_rdata; end
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic              got, wr_seen, rd_early, we_seen, rv_seen;
    logic [DATA_W-1:0] rdata;

    rst = 1'b1; pix_en = 1'b0; video_on = 1'b0; posx = '0; posy = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset cycles with a display slot and a read request present at the inputs
    @(negedge clk);
    pix_en = 1'b1; video_on = 1'b1; posx = 10'd5; posy = 10'd2; cpu_req = 1'b1;
    #1;
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    @(negedge clk);
    #1;
    check("rst_rvalid", cpu_rvalid, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_pixel_data", pixel_data, 0);
    @(negedge clk);
    rst = 1'b0; pix_en = 1'b0; video_on = 1'b0; cpu_req = 1'b0;

    // Preload two pixels through the CPU path during blanking
    cpu_op(1'b1, 19'd1285, 8'h3C);
    cpu_op(1'b1, 19'd1286, 8'h5A);
    repeat (3) @(negedge clk);
    check("preload_count", wlog.size(), 2);
    check("preload0", wlog[0], {19'd1285, 8'h3C});
    check("preload1", wlog[1], {19'd1286, 8'h5A});
    wlog.delete();

    // Display reads with pix_en every second cycle
    pix_en = 1'b1; video_on = 1'b1; posx = 10'd5; posy = 10'd2;
    #1;
    check("disp_addr_1285", ram_addr, 1285);
    check("disp_we", ram_we, 0);
    @(negedge clk);
    pix_en = 1'b0;
    #1;
    check("disp_valid_early", pixel_valid, 0);
    @(negedge clk);
    pix_en = 1'b1; posx = 10'd6;
    #1;
    check("disp_valid_1", pixel_valid, 1);
    check("disp_data_1285", pixel_data, 8'h3C);
    check("disp_addr_1286", ram_addr, 1286);
    @(negedge clk);
    pix_en = 1'b0;
    #1;
    check("disp_valid_gap", pixel_valid, 0);
    check("disp_data_hold", pixel_data, 8'h3C);
    @(negedge clk);
    pix_en = 1'b1; video_on = 1'b0;
    #1;
    check("disp_valid_2", pixel_valid, 1);
    check("disp_data_1286", pixel_data, 8'h5A);
    @(negedge clk);
    pix_en = 1'b0;
    @(negedge clk);
    #1;
    check("blank_valid", pixel_valid, 0);
    check("blank_data", pixel_data, 0);
    @(negedge clk);

    // Five back-to-back writes while display owns every slot
    pix_en = 1'b1; video_on = 1'b1; posx = '0; posy = '0;
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = ADDR_W'(10 + i); cpu_wdata = DATA_W'(8'h10 + i);
      #1;
      check("fill_ready", cpu_ready, 1);
      check("fill_no_we", ram_we, 0);
      @(negedge clk);
    end
    cpu_addr = 19'd14; cpu_wdata = 8'h14;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("full_ready", cpu_ready, 0);
      check("full_no_we", ram_we, 0);
      @(negedge clk);
    end
    pix_en = 1'b0; video_on = 1'b0;
    #1;
    check("full_pop_ready", cpu_ready, 0);
    check("full_pop_we", ram_we, 1);
    check("full_pop_addr", ram_addr, 10);
    check("full_pop_wdata", ram_wdata, 8'h10);
    @(negedge clk);
    #1;
    check("after_pop_ready", cpu_ready, 1);
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (6) @(negedge clk);
    check("fill_drain_count", wlog.size(), 5);
    for (int i = 0; i < 5; i++)
      check("fill_order", wlog[i], {ADDR_W'(10 + i), DATA_W'(8'h10 + i)});
    wlog.delete();

    // Read ordered behind a posted write while display is active
    pix_en = 1'b1; video_on = 1'b1;
    cpu_op(1'b1, 19'd100, 8'hA5);
    cpu_op(1'b0, 19'd100, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ord_hold_we", ram_we, 0);
      check("ord_hold_rvalid", cpu_rvalid, 0);
      @(negedge clk);
    end
    got = 1'b0; wr_seen = 1'b0; rd_early = 1'b0; rdata = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      pix_en = (i % 2 == 1);
      #1;
      if (ram_we && ram_addr == 19'd100) wr_seen = 1'b1;
      if (!pix_en && !ram_we && ram_addr == 19'd100 && !wr_seen) rd_early = 1'b1;
      if (cpu_rvalid) begin got = 1'b1; rdata = cpu_rdata; end
      @(negedge clk);
    end
    check("ord_rvalid", got, 1);
    check("ord_rdata", rdata, 8'hA5);
    check("ord_write_seen", wr_seen, 1);
    check("ord_read_early", rd_early, 0);
    pix_en = 1'b0; video_on = 1'b0;
    wlog.delete();

    // Out-of-range write is dropped, out-of-range read returns zero
    cpu_op(1'b1, 19'd307200, 8'h77);
    repeat (3) @(negedge clk);
    check("oob_wr_dropped", wlog.size(), 0);
    cpu_op(1'b0, 19'd307200, 8'h00);
    wait_rvalid(got, rdata);
    check("oob_rvalid", got, 1);
    check("oob_rdata", rdata, 0);

    // Reset while a read is pending behind three queued writes
    pix_en = 1'b1; video_on = 1'b1;
    cpu_op(1'b1, 19'd200, 8'h01);
    cpu_op(1'b1, 19'd201, 8'h02);
    cpu_op(1'b1, 19'd202, 8'h03);
    cpu_op(1'b0, 19'd200, 8'h00);
    rst = 1'b1;
    #1;
    check("mid_rst_we", ram_we, 0);
    @(negedge clk);
    rst = 1'b0; pix_en = 1'b0; video_on = 1'b0;
    we_seen = 1'b0; rv_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (ram_we) we_seen = 1'b1;
      if (cpu_rvalid) rv_seen = 1'b1;
      @(negedge clk);
    end
    check("post_rst_no_we", we_seen, 0);
    check("post_rst_no_rvalid", rv_seen, 0);
    check("post_rst_wlog", wlog.size(), 0);

    // Arbiter still serves a fresh write/read pair after the reset
    cpu_op(1'b1, 19'd300, 8'h42);
    cpu_op(1'b0, 19'd300, 8'h00);
    wait_rvalid(got, rdata);
    check("post_rst_rvalid", got, 1);
    check("post_rst_rdata", rdata, 8'h42);
    check("post_rst_wr", wlog.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
